data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 8: word-index width; depth = 2^ADDR_W words of 32 bits.
REQ-002 Parameter CHECK_RANGE, default 1: 1 = addresses with any of sram_addr[31:ADDR_W+2] set are treated as out-of-range.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 sram_en  input  1  access request this cycle.
REQ-006 sram_wen  input  4  byte write enables; wen[i] writes byte lane i (bits 8i+7:8i); 0000 = read.
REQ-007 sram_addr  input  32  byte address; word index = sram_addr[ADDR_W+1:2]; sram_addr[1:0] is ignored.
REQ-008 sram_wdata  input  32  write data.
REQ-009 sram_rdata  output  32  registered read data, valid the cycle after the access.
REQ-010 dbg_addr  input  32  display/debug byte address; index = dbg_addr[ADDR_W+1:2].
REQ-011 dbg_rdata  output  32  registered debug read data.
REQ-012 clr_cnt  input  1  synchronous clear of the access counters.
REQ-013 rd_cnt  output  32  count of accepted reads.
REQ-014 wr_cnt  output  32  count of accepted writes.
REQ-015 range_err  output  1  sticky out-of-range access flag.

Function
REQ-016 Access accepted: sram_en=1 and address in range (CHECK_RANGE=0 means always in range).
REQ-017 Accepted read (wen=0000): sram_rdata <= mem[idx] at the next edge; latency is exactly 1 cycle.
REQ-018 Accepted write (wen!=0000): only enabled byte lanes of mem[idx] update; disabled lanes are kept.
REQ-019 A write also returns data on sram_rdata: the merged new word, write-first.
REQ-020 sram_en=0: no memory change; sram_rdata holds its previous value.
REQ-021 Out-of-range access with sram_en=1: no memory change; sram_rdata <= 0; range_err <= 1.
REQ-022 range_err stays set until reset; clr_cnt does not clear it.
REQ-023 Debug port: dbg_rdata <= mem[dbg_idx] every cycle, with no enable and no range check.
REQ-024 Debug port reads first: if a write to dbg_idx happens in the same cycle, dbg_rdata returns the pre-write word.
REQ-025 Counters: rd_cnt increments by 1 per accepted read; wr_cnt increments by 1 per accepted write.
REQ-026 Counters saturate at 32'hFFFF_FFFF and do not wrap.
REQ-027 Out-of-range accesses are not counted.
REQ-028 clr_cnt=1 clears both counters to 0 and takes priority over a same-cycle increment.
REQ-029 Back-to-back accesses are accepted every cycle.
REQ-030 Read immediately after a write to the same index returns the written data.

Reset
REQ-031 resetn=0 immediately sets sram_rdata=0, dbg_rdata=0, rd_cnt=0, wr_cnt=0 and range_err=0, independent of clk.
REQ-032 While resetn=0, no memory write occurs, including a write presented in the same cycle reset asserts.
REQ-033 Memory contents are not cleared by reset; words not yet written read as X in simulation.
REQ-034 The first access is accepted on the first rising edge after resetn deasserts.

Verification
REQ-035 Write then read: write 0x1234_5678 to addr 0x10 with wen=1111, then read 0x10 -> sram_rdata=0x1234_5678 one cycle after the read; wr_cnt=1, rd_cnt=1.
REQ-036 Byte merge: mem[4]=0xAABB_CCDD; write 0x1122_3344 to addr 0x10 with wen=0101 -> write-cycle rdata=0xAA22_CC44; a later read of 0x10 returns 0xAA22_CC44.
REQ-037 Debug collision: dbg_addr=0x20 with mem[8]=0x0; write 0xFFFF_FFFF to 0x20 -> dbg_rdata=0x0 next cycle and 0xFFFF_FFFF the cycle after.
REQ-038 Range check: CHECK_RANGE=1, write 0x5 to 0x0000_0400 -> mem[0] unchanged, sram_rdata=0, range_err=1, wr_cnt unchanged; clr_cnt pulse leaves range_err=1.
REQ-039 Counter edge cases: force rd_cnt=0xFFFF_FFFF, then one read -> stays 0xFFFF_FFFF; clr_cnt together with a read -> rd_cnt=0.
REQ-040 Reset mid-operation: assert resetn low between edges during a write burst -> outputs clear immediately, the write in the reset cycle is not committed, and earlier writes are still readable after release.

Source files
------------

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : data_sram_resp
//  Brief    : 32-bit word SRAM model with byte-lane writes, a 1-cycle
//             registered response, an always-on debug read port, saturating
//             access counters and a sticky out-of-range flag.
//  Revision : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
    parameter int ADDR_W      = 8,
    parameter int CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata,
    input  logic        clr_cnt,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic        range_err
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [31:0]       mem [c_depth];
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_dbg_idx;
    logic              w_in_range;
    logic              w_is_wr;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [31:0]       w_merged;
    logic              w_unused_bits;

    logic [31:0]       r_sram_rdata;
    logic [31:0]       r_dbg_rdata;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;
    logic              r_range_err;

    assign w_idx         = sram_addr[ADDR_W+1:2];
    assign w_dbg_idx     = dbg_addr[ADDR_W+1:2];
    assign w_is_wr       = |sram_wen;
    assign w_unused_bits = ^{dbg_addr, sram_addr[1:0]};

    generate
        if (CHECK_RANGE != 0 && ADDR_W < 30) begin : g_range_chk
            assign w_in_range = ~|sram_addr[31:ADDR_W+2];
        end else begin : g_range_none
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_rd_acc = sram_en & w_in_range & ~w_is_wr;
    assign w_wr_acc = sram_en & w_in_range &  w_is_wr;

    // Write-first response: the word as it will look after this cycle's write.
    always_comb begin
        w_merged = mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (sram_wen[i]) begin
                w_merged[8*i +: 8] = sram_wdata[8*i +: 8];
            end
        end
    end

    // Memory lives under the reset branch so a write presented while resetn
    // is low is never committed; its contents are deliberately not cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sram_rdata <= '0;
            r_dbg_rdata  <= '0;
            r_range_err  <= 1'b0;
        end else begin
            r_dbg_rdata <= mem[w_dbg_idx];
            if (sram_en) begin
                if (w_in_range) begin
                    r_sram_rdata <= w_merged;
                    if (w_is_wr) begin
                        mem[w_idx] <= w_merged;
                    end
                end else begin
                    r_sram_rdata <= '0;
                    r_range_err  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (clr_cnt) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_acc && r_rd_cnt != 32'hFFFF_FFFF) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_acc && r_wr_cnt != 32'hFFFF_FFFF) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign sram_rdata = r_sram_rdata;
    assign dbg_rdata  = r_dbg_rdata;
    assign rd_cnt     = r_rd_cnt;
    assign wr_cnt     = r_wr_cnt;
    assign range_err  = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_sram_resp
//  Brief    : Directed self-checking bench for data_sram_resp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;
    logic        clr_cnt;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic        range_err;

    int n_checks;
    int n_fail;

    data_sram_resp #(
        .ADDR_W      (8),
        .CHECK_RANGE (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .clr_cnt    (clr_cnt),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .range_err  (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b1;
        clr_cnt  = 1'b0;
        dbg_addr = 32'h0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);

        #1 resetn = 1'b0;
        #2;
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_dbg",   dbg_rdata,  32'h0);
        check("rst_rdcnt", rd_cnt,     32'h0);
        check("rst_wrcnt", wr_cnt,     32'h0);
        check("rst_rerr",  {31'h0, range_err}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Write then read, back to back
        drive(1'b1, 4'hF, 32'h10, 32'h1234_5678);
        tick();
        check("wr_resp", sram_rdata, 32'h1234_5678);
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("rd_after_wr", sram_rdata, 32'h1234_5678);
        check("wrcnt_1", wr_cnt, 32'd1);
        check("rdcnt_1", rd_cnt, 32'd1);
        drive(1'b0, 4'hF, 32'h10, 32'hDEAD_0000);
        tick();
        check("idle_hold", sram_rdata, 32'h1234_5678);
        check("idle_wrcnt", wr_cnt, 32'd1);

        // Byte-lane merge
        drive(1'b1, 4'hF, 32'h10, 32'hAABB_CCDD);
        tick();
        drive(1'b1, 4'b0101, 32'h13, 32'h1122_3344);
        tick();
        check("merge_resp", sram_rdata, 32'hAA22_CC44);
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("merge_rd", sram_rdata, 32'hAA22_CC44);
        check("wrcnt_3", wr_cnt, 32'd3);
        check("rdcnt_2", rd_cnt, 32'd2);

        // Debug port returns the pre-write word on collision
        dbg_addr = 32'h20;
        drive(1'b1, 4'hF, 32'h20, 32'h0);
        tick();
        drive(1'b1, 4'hF, 32'h20, 32'hFFFF_FFFF);
        tick();
        check("dbg_collide", dbg_rdata, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("dbg_after", dbg_rdata, 32'hFFFF_FFFF);

        // Out-of-range write aliases index 0 but must not touch it
        drive(1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);
        tick();
        check("wrcnt_6", wr_cnt, 32'd6);
        drive(1'b1, 4'hF, 32'h0000_0400, 32'h5);
        tick();
        check("oor_rdata", sram_rdata, 32'h0);
        check("oor_rerr",  {31'h0, range_err}, 32'h1);
        check("oor_wrcnt", wr_cnt, 32'd6);
        dbg_addr = 32'h0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        clr_cnt  = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        check("oor_mem0",  dbg_rdata, 32'hCAFE_F00D);
        check("clr_rerr",  {31'h0, range_err}, 32'h1);
        check("clr_wrcnt", wr_cnt, 32'h0);

        // Counter saturation and clear priority
        force dut.r_rd_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_rd_cnt;
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("rd_sat", rd_cnt, 32'hFFFF_FFFF);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_prio", rd_cnt, 32'h0);
        check("clr_rd_data", sram_rdata, 32'hAA22_CC44);

        // Asynchronous reset in the middle of a write burst
        drive(1'b1, 4'hF, 32'h30, 32'h0BAD_BEEF);
        tick();
        drive(1'b1, 4'hF, 32'h30, 32'hDEAD_DEAD);
        #2 resetn = 1'b0;
        #1;
        check("mid_rdata", sram_rdata, 32'h0);
        check("mid_wrcnt", wr_cnt, 32'h0);
        check("mid_rerr",  {31'h0, range_err}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn   = 1'b1;
        dbg_addr = 32'h30;
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        check("post_dbg",   dbg_rdata,  32'h0BAD_BEEF);
        check("post_rd",    sram_rdata, 32'hAA22_CC44);
        check("post_rdcnt", rd_cnt,     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
